// File: rtl/vga_scaled_timing.sv
// VGA sync/timing generator with 2^SCALE_LOG2 upscaled framebuffer addressing,
// framebuffer read-latency compensation and a frame-synchronous colour-bar test mode.
module vga_scaled_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SCALE_LOG2 = 2,
    parameter int RD_LAT     = 1,
    parameter int RGB_W      = 3,
    parameter int ADDR_W     = 15,
    parameter int CNT_W      = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic [RGB_W-1:0]  pixel_rgb,
    output logic [ADDR_W-1:0] pixel_address,
    output logic [RGB_W-1:0]  vga_rgb,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start,
    output logic              line_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH = RD_LAT + 1;
    localparam int REP   = (RGB_W + 2) / 3;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] SUB_MASK = CNT_W'((1 << SCALE_LOG2) - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

    // Per-pixel control flags; syncs are carried as "asserted" so a cleared stage is idle.
    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       frame;
        logic       line;
        logic       bars;
        logic [2:0] bar;
    } stage_t;

    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  v;
    logic [CNT_W-1:0]  bar_cnt;
    logic [2:0]        bar_idx;
    logic [ADDR_W-1:0] line_base;
    logic              mode_f;
    logic              h_wrap;
    logic              v_wrap;
    logic              at_origin;
    logic              active0;
    stage_t            s0;
    stage_t            pipe [DEPTH];
    stage_t            tail;
    logic [3*REP-1:0]  bar_rep;
    logic [RGB_W-1:0]  rgb_next;

    assign h_wrap    = (h == H_LAST);
    assign v_wrap    = (v == V_LAST);
    assign at_origin = (h == '0) && (v == '0);
    assign active0   = (h < H_ACT) && (v < V_ACT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            line_base <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
        end else if (h_wrap) begin
            h       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            if (v_wrap) begin
                v         <= '0;
                line_base <= '0;
            end else begin
                v <= v + ONE;
                // Advance one framebuffer row after the last replicated scan line of it.
                if ((v < V_ACT) && ((v & SUB_MASK) == SUB_MASK))
                    line_base <= line_base + LINE_STEP;
            end
        end else begin
            h <= h + ONE;
            if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + ONE;
            end
        end
    end

    // Mode is only allowed to change at the top-left pixel so a frame is never mixed.
    always_ff @(posedge clock) begin
        if (reset)
            mode_f <= 1'b0;
        else if (at_origin)
            mode_f <= mode;
    end

    always_comb begin
        s0.active = active0;
        s0.hsync  = (h >= HS_BEGIN) && (h < HS_END);
        s0.vsync  = (v >= VS_BEGIN) && (v < VS_END);
        s0.frame  = at_origin;
        s0.line   = (h == '0) && (v < V_ACT);
        s0.bars   = at_origin ? mode : mode_f;
        s0.bar    = bar_idx;
    end

    always_ff @(posedge clock) begin
        if (reset)
            pixel_address <= '0;
        else
            pixel_address <= active0 ? line_base + ADDR_W'(h >> SCALE_LOG2) : '0;
    end

    // NOTE: the delay line is a few flops, not a RAM, so it is cleared on reset;
    // that keeps every output idle until real pixels reach the end of the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < DEPTH; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign tail    = pipe[DEPTH-1];
    assign bar_rep = {REP{tail.bar}};

    // NOTE: default first so no path through the block leaves rgb_next unassigned (no latch).
    always_comb begin
        rgb_next = '0;
        if (tail.active)
            rgb_next = tail.bars ? bar_rep[RGB_W-1:0] : pixel_rgb;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_rgb     <= '0;
            vga_hsync   <= !SYNC_POL;
            vga_vsync   <= !SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_rgb     <= rgb_next;
            vga_hsync   <= tail.hsync ? SYNC_POL : !SYNC_POL;
            vga_vsync   <= tail.vsync ? SYNC_POL : !SYNC_POL;
            frame_start <= tail.frame;
            line_start  <= tail.line;
        end
    end

endmodule
